// File: rtl/vt_term_engine.sv
// rtl/vt_term_engine.sv - VT52-style terminal byte engine driving a scrolling character cell memory
// Control bytes and escape sequences move the cursor; printables write one cell; scroll/erase runs a cell clear.
module vt_term_engine #(
  parameter int COLS = 80,
  parameter int ROWS = 24,
  parameter int AW   = 11,
  localparam int CW  = $clog2(COLS),
  localparam int RW  = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  input  logic          autowrap,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic [CW-1:0] cur_x,
  output logic [RW-1:0] cur_y_mem,
  output logic [RW-1:0] topline,
  output logic          bell
);

  typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

  localparam logic [CW-1:0] X_MAX    = CW'(COLS - 1);
  localparam logic [RW-1:0] Y_MAX    = RW'(ROWS - 1);
  localparam logic [AW-1:0] LAST_COL = AW'(COLS - 1);
  localparam logic [AW-1:0] LAST_CELL = AW'(COLS * ROWS - 1);

  state_t        state, state_n;
  logic [RW-1:0] cur_y, cy_n, top_n;
  logic [CW-1:0] cx_n;
  logic          esc, esc_n, wrap_pending, wrap_n, wrap_en, wen_n, wr_after, wa_n, bell_n;
  logic [1:0]    addr_mode, am_n;
  logic [7:0]    wr_data, wd_n, param;
  logic [AW-1:0] clr_addr, ca_n, clr_end, ce_n, cur_addr;
  logic [RW-1:0] top_inc, top_dec;
  logic [CW:0]   tab;

  function automatic logic [AW-1:0] row_base(input logic [RW-1:0] r);
    return AW'(r) * AW'(COLS);
  endfunction

  function automatic logic [RW-1:0] phys_row(input logic [RW-1:0] y, input logic [RW-1:0] t);
    logic [RW:0] s;
    s = {1'b0, y} + {1'b0, t};
    if (s >= (RW+1)'(ROWS)) s = s - (RW+1)'(ROWS);
    return s[RW-1:0];
  endfunction

  assign cur_y_mem = phys_row(cur_y, topline);
  assign cur_addr  = row_base(cur_y_mem) + AW'(cur_x);
  assign top_inc   = (topline == Y_MAX) ? '0 : topline + 1'b1;
  assign top_dec   = (topline == '0) ? Y_MAX : topline - 1'b1;
  assign param     = in_data - 8'h20;
  assign tab       = ({1'b0, cur_x} & ~(CW+1)'(7)) + (CW+1)'(8);

  // Reset parks the FSM in CLEAR over the whole screen; the strobe is held off until release.
  assign in_ready  = (state == IDLE);
  assign mem_we    = (state != IDLE) && !reset;
  assign mem_addr  = (state == CLEAR) ? clr_addr : cur_addr;
  assign mem_wdata = (state == WRITE) ? wr_data : 8'h00;

  always_comb begin
    state_n = state;   cx_n = cur_x;     cy_n = cur_y;        top_n = topline;
    esc_n   = esc;     am_n = addr_mode; wrap_n = wrap_pending; wen_n = wrap_en;
    wd_n    = wr_data; wa_n = wr_after;  ca_n = clr_addr;     ce_n = clr_end;
    bell_n  = 1'b0;
    case (state)
      IDLE: if (in_valid) begin
        if (addr_mode == 2'd1) begin
          am_n = 2'd2; wrap_n = 1'b0;
          if (in_data >= 8'h20 && 32'(param) < ROWS) cy_n = param[RW-1:0];
        end else if (addr_mode == 2'd2) begin
          am_n = 2'd0; wrap_n = 1'b0;
          if (in_data >= 8'h20) cx_n = (32'(param) >= COLS) ? X_MAX : param[CW-1:0];
        end else if (esc) begin
          esc_n = 1'b0; wrap_n = 1'b0;
          case (in_data)
            8'h41: if (cur_y != '0) cy_n = cur_y - 1'b1;
            8'h42: if (cur_y != Y_MAX) cy_n = cur_y + 1'b1;
            8'h43: if (cur_x != X_MAX) cx_n = cur_x + 1'b1;
            8'h44: if (cur_x != '0) cx_n = cur_x - 1'b1;
            8'h48: begin cx_n = '0; cy_n = '0; end
            8'h49: if (cur_y != '0) cy_n = cur_y - 1'b1;
                   else begin
                     top_n = top_dec; ca_n = row_base(top_dec);
                     ce_n = row_base(top_dec) + LAST_COL; state_n = CLEAR;
                   end
            8'h4A: begin ca_n = cur_addr; ce_n = row_base(top_dec) + LAST_COL; state_n = CLEAR; end
            8'h4B: begin ca_n = cur_addr; ce_n = row_base(cur_y_mem) + LAST_COL; state_n = CLEAR; end
            8'h59: am_n = 2'd1;
            default: ;
          endcase
        end else if (in_data >= 8'h20 && in_data <= 8'h7E) begin
          wd_n = in_data; wen_n = autowrap; state_n = WRITE;
          if (wrap_pending) begin
            // Deferred wrap: CR+LF first, scrolling through a line clear when on the bottom line.
            wrap_n = 1'b0; cx_n = '0;
            if (cur_y == Y_MAX) begin
              top_n = top_inc; ca_n = row_base(topline);
              ce_n = row_base(topline) + LAST_COL; wa_n = 1'b1; state_n = CLEAR;
            end else cy_n = cur_y + 1'b1;
          end
        end else begin
          case (in_data)
            8'h07: begin bell_n = 1'b1; wrap_n = 1'b0; end
            8'h08: begin wrap_n = 1'b0; if (cur_x != '0) cx_n = cur_x - 1'b1; end
            8'h09: begin wrap_n = 1'b0; cx_n = (32'(tab) > COLS - 1) ? X_MAX : tab[CW-1:0]; end
            8'h0D: begin wrap_n = 1'b0; cx_n = '0; end
            8'h1B: begin wrap_n = 1'b0; esc_n = 1'b1; end
            8'h0A: begin
              wrap_n = 1'b0;
              if (cur_y != Y_MAX) cy_n = cur_y + 1'b1;
              else begin
                top_n = top_inc; ca_n = row_base(topline);
                ce_n = row_base(topline) + LAST_COL; state_n = CLEAR;
              end
            end
            default: ;
          endcase
        end
      end
      WRITE: begin
        state_n = IDLE;
        if (cur_x != X_MAX) cx_n = cur_x + 1'b1;
        else if (wrap_en) wrap_n = 1'b1;
      end
      default: begin
        if (clr_addr == clr_end) begin
          state_n = wr_after ? WRITE : IDLE;
          wa_n = 1'b0;
        end else begin
          ca_n = (clr_addr == LAST_CELL) ? '0 : clr_addr + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CLEAR;   cur_x <= '0;     cur_y <= '0;        topline <= '0;
      esc <= 1'b0;      addr_mode <= '0; wrap_pending <= 1'b0; wrap_en <= 1'b0;
      wr_data <= '0;    wr_after <= 1'b0; clr_addr <= '0;    clr_end <= LAST_CELL;
      bell <= 1'b0;
    end else begin
      state <= state_n; cur_x <= cx_n;   cur_y <= cy_n;      topline <= top_n;
      esc <= esc_n;     addr_mode <= am_n; wrap_pending <= wrap_n; wrap_en <= wen_n;
      wr_data <= wd_n;  wr_after <= wa_n; clr_addr <= ca_n;  clr_end <= ce_n;
      bell <= bell_n;
    end
  end

endmodule
